// File: rtl/aes_sbox_array.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sbox_array
//  Purpose  : Pipelined multi-byte AES SubBytes / InvSubBytes engine with
//             valid/ready handshake on both sides, a bubble-collapsing
//             pipeline and full backpressure. The forward/inverse mode is
//             chosen per beat and travels with the data.
//  Options  : AES_SBOX_PARITY_EN - adds out_parity, per-byte even parity of
//             the substituted byte, taken from a separate parity table that
//             is indexed by the input byte.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_sbox_array #(
    parameter int NUM_BYTES   = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inverse,
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_inverse,
    output logic [8*NUM_BYTES-1:0] out_data
`ifdef AES_SBOX_PARITY_EN
    ,
    output logic [NUM_BYTES-1:0]   out_parity
`endif
);

    localparam int c_width = 8 * NUM_BYTES;

    // Forward S-box, entry 0 in the most significant byte, one row of 16
    // entries per line (row n holds inputs 8'hn0 .. 8'hnF).
    localparam logic [2047:0] c_sbox_fwd = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, same layout as the forward table.
    localparam logic [2047:0] c_sbox_inv = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return c_sbox_fwd[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return c_sbox_inv[2047 - 8*int'(b) -: 8];
    endfunction

`ifdef AES_SBOX_PARITY_EN
    // Builds a 256-entry parity table at elaboration; bit i is the parity of
    // the substitution of input byte i. It is its own ROM, so a corrupted
    // data bit later in the pipe shows up as a parity mismatch downstream.
    function automatic logic [255:0] gen_parity(input logic inverse);
        logic [255:0] t;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            t[i] = inverse ? ^sbox_inv(8'(i)) : ^sbox_fwd(8'(i));
        end
        return t;
    endfunction

    localparam logic [255:0] c_par_fwd = gen_parity(1'b0);
    localparam logic [255:0] c_par_inv = gen_parity(1'b1);
`endif

    // ------------------------------------------------------------------
    // Per-byte lookup; bytes are fully independent of each other.
    // ------------------------------------------------------------------
    logic [c_width-1:0]   w_sub;
`ifdef AES_SBOX_PARITY_EN
    logic [NUM_BYTES-1:0] w_par;
`endif

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_byte
        logic [7:0] w_in_byte;
        assign w_in_byte        = in_data[8*i +: 8];
        assign w_sub[8*i +: 8]  = in_inverse ? sbox_inv(w_in_byte) : sbox_fwd(w_in_byte);
`ifdef AES_SBOX_PARITY_EN
        assign w_par[i]         = in_inverse ? c_par_inv[w_in_byte] : c_par_fwd[w_in_byte];
`endif
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [PIPE_STAGES-1:0] r_valid;
    logic [PIPE_STAGES-1:0] r_inv;
    logic [c_width-1:0]     r_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] w_load;

    // A stage may load when it or any stage after it is empty, or when the
    // last stage is being drained. Written as a reduction over the valid
    // bits so each load bit depends only on registers and out_ready.
    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_load
        assign w_load[k] = out_ready || !(&r_valid[PIPE_STAGES-1:k]);
    end

    assign in_ready = w_load[0];

    // Stage 0 captures the looked-up beat; later stages shift forward when
    // allowed. Invalid beats still load data, only the valid bit matters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_inv   <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= in_valid;
                r_inv[0]   <= in_inverse;
                r_data[0]  <= w_sub;
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    r_inv[k]   <= r_inv[k-1];
                    r_data[k]  <= r_data[k-1];
                end
            end
        end
    end

`ifdef AES_SBOX_PARITY_EN
    logic [NUM_BYTES-1:0] r_par [PIPE_STAGES];

    // Parity bits ride alongside the data with the same load enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                r_par[k] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_par[0] <= w_par;
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_load[k]) begin
                    r_par[k] <= r_par[k-1];
                end
            end
        end
    end

    assign out_parity = r_par[PIPE_STAGES-1];
`endif

    assign out_valid   = r_valid[PIPE_STAGES-1];
    assign out_inverse = r_inv[PIPE_STAGES-1];
    assign out_data    = r_data[PIPE_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_sbox_array
//  Purpose  : Scoreboard bench for aes_sbox_array. Expected beats come from a
//             GF(2^8) reference model (multiplicative inverse + affine map),
//             a monitor pops and compares on every output transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_sbox_array;

    localparam int NB = 4;
    localparam int PS = 2;
    localparam int W  = 8 * NB;

    typedef struct {
        logic [W-1:0]  data;
        logic          inv;
        logic [NB-1:0] par;
    } exp_t;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          in_valid   = 1'b0;
    logic          in_ready;
    logic          in_inverse = 1'b0;
    logic [W-1:0]  in_data    = '0;
    logic          out_valid;
    logic          out_ready  = 1'b0;
    logic          out_inverse;
    logic [W-1:0]  out_data;
`ifdef AES_SBOX_PARITY_EN
    logic [NB-1:0] out_parity;
`endif

    aes_sbox_array #(
        .NUM_BYTES   (NB),
        .PIPE_STAGES (PS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inverse  (in_inverse),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inverse (out_inverse),
        .out_data    (out_data)
`ifdef AES_SBOX_PARITY_EN
        ,
        .out_parity  (out_parity)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_sent   = 0;
    int   n_emit   = 0;
    int   occ;
    exp_t sb [$];

    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a, p;
        logic       hi;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_model();
        logic [7:0] x, g, s;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            g = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) g = 8'(y);
            end
            s = g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
            m_fwd[v] = s;
            m_inv[s] = x;
        end
    endtask

    function automatic logic [NB-1:0] par_of(input logic [W-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    function automatic exp_t model_exp(input logic [W-1:0] d, input logic inv);
        exp_t e;
        e.inv = inv;
        for (int i = 0; i < NB; i++) begin
            e.data[8*i +: 8] = inv ? m_inv[d[8*i +: 8]] : m_fwd[d[8*i +: 8]];
        end
        e.par = par_of(e.data);
        return e;
    endfunction

    function automatic exp_t lit_exp(input logic [W-1:0] d, input logic inv);
        exp_t e;
        e.data = d;
        e.inv  = inv;
        e.par  = par_of(d);
        return e;
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the beat transferred.
    task automatic send(input logic [W-1:0] d, input logic inv, input exp_t e);
        int   waited;
        logic ok;
        waited     = 0;
        ok         = 1'b0;
        in_valid   = 1'b1;
        in_data    = d;
        in_inverse = inv;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else waited++;
        end
        if (ok) begin
            sb.push_back(e);
            n_sent++;
        end else begin
            chk("send_accept", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_data    = $urandom;
        in_inverse = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sb.size() != 0 && n < 200);
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // ---------------- occupancy model ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ <= 0;
        else occ <= occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end

    // ---------------- monitor ----------------
    logic         stall_prev = 1'b0;
    logic [W-1:0] hold_data  = '0;
    logic         hold_inv   = 1'b0;
    exp_t         m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'((occ < PS) || out_ready));
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_beat", 64'({out_inverse, out_data}), 64'({hold_inv, hold_data}));
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    m_e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(m_e.data));
                    chk("out_inverse", 64'(out_inverse), 64'(m_e.inv));
`ifdef AES_SBOX_PARITY_EN
                    chk("out_parity", 64'(out_parity), 64'(m_e.par));
`endif
                end
                n_emit++;
            end
            stall_prev = out_valid && !out_ready;
            hold_data  = out_data;
            hold_inv   = out_inverse;
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] d, s, bp_d, rd, hd;
    logic         bp_m, rm, rnd_done;
    int           lat, cyc, base_sent, base_emit;
    time          t0;

    initial begin
        build_model();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_inverse", 64'(out_inverse), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef AES_SBOX_PARITY_EN
        chk("rst_out_parity", 64'(out_parity), 64'd0);
`endif
        @(posedge clk);
        #1;

        // forward known vector and latency
        out_ready = 1'b1;
        send(32'h5301_0063, 1'b0, lit_exp(32'hED7C_63FB, 1'b0));
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            if (!out_valid) lat++;
        end
        chk("latency", 64'(lat), 64'(PS));
        drain("drain_fwd_vec");

        // inverse known vectors
        send(32'hED7C_6300, 1'b1, lit_exp(32'h5301_0052, 1'b1));
        send(32'h0000_FF01, 1'b1, lit_exp(32'h5252_7D09, 1'b1));
        drain("drain_inv_vec");

        // exhaustive round trip, alternating mode every beat
        t0 = $time;
        for (int g = 0; g < 256 / NB; g++) begin
            for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'(g * NB + i);
            s = model_exp(d, 1'b0).data;
            send(d, 1'b0, model_exp(d, 1'b0));
            send(s, 1'b1, lit_exp(d, 1'b1));
        end
        chk("no_bubble", 64'(($time - t0) / 10), 64'(2 * 256 / NB));
        drain("drain_roundtrip");

        // backpressure: 5 beats against a stalled output
        out_ready = 1'b0;
        base_sent = n_sent;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    bp_d      = $urandom;
                    bp_d[7:0] = 8'(i);
                    bp_m      = 1'($urandom_range(0, 1));
                    send(bp_d, bp_m, model_exp(bp_d, bp_m));
                end
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                #1;
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_accepted", 64'(n_sent - base_sent), 64'(PS));
                hd = out_data;
                repeat (3) @(negedge clk);
                #1;
                chk("bp_stable", 64'(out_data), 64'(hd));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                base_emit = n_emit;
                cyc = 0;
                while ((n_emit - base_emit) < 5 && cyc < 50) begin
                    @(negedge clk);
                    #1;
                    cyc++;
                end
                chk("bp_rate", 64'(cyc), 64'd5);
            end
        join
        drain("drain_bp");

        // random traffic
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    while ($urandom_range(0, 1) == 0) begin
                        in_valid = 1'b0;
                        in_data  = $urandom;
                        @(posedge clk);
                        #1;
                    end
                    rd = $urandom;
                    rm = 1'($urandom_range(0, 1));
                    send(rd, rm, model_exp(rd, rm));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_random");

        // reset with two beats in flight
        out_ready = 1'b0;
        send(32'h1122_3344, 1'b0, model_exp(32'h1122_3344, 1'b0));
        send(32'hA5A5_5A5A, 1'b1, model_exp(32'hA5A5_5A5A, 1'b1));
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_data", 64'(out_data), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'h0000_0100, 1'b0, lit_exp(32'h6363_7C63, 1'b0));
        drain("drain_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d beats outstanding", sb.size());
        $fatal(1);
    end

endmodule
`default_nettype wire
